instruction_fetch_stage: RTL and testbench

Pipeline fetch stage with its IF/ID pipeline register. It holds the program counter, drives the instruction ROM address, and captures the returned word with its PC+4 into the IF/ID register for decode. It applies branch redirection, hazard freeze and flush. It also keeps a retired-fetch counter for the lab's performance readout. It sits between the hazard/branch logic in ID/EXE and the combinational instruction ROM.

---
 rtl/instruction_fetch_stage.sv | 75 +++++++
 tb/tb_instruction_fetch_stage.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: program counter, combinational ROM addressing, and the IF/ID
// pipeline register with branch redirect, hazard freeze, flush and a fetch counter.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] rom_address,
  input  logic [31:0] rom_inst,
  output logic [31:0] if_pc,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic        id_valid,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] STEP = 32'(PC_STEP);
  localparam logic [31:0] NOP  = 32'h0000_0000;

  logic [31:0] pc_q;
  logic [31:0] pc_plus_step;
  logic [31:0] pc_redirect;
  logic        bubble_load;
  logic        valid_load;

  // Modulo-2^32 increment: the top word wraps back to address zero.
  assign pc_plus_step = pc_q + STEP;
  assign pc_redirect  = {branch_target[31:2], 2'b00};

  // A taken branch kills the word fetched this cycle, even while frozen.
  assign bubble_load  = flush || branch_taken;
  assign valid_load   = !bubble_load && !freeze;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (branch_taken) begin
      pc_q <= pc_redirect;
    end else if (!freeze) begin
      pc_q <= pc_plus_step;
    end
  end

  // id_valid qualifies id_inst/id_pc: when low the register holds a NOP bubble
  // and decode must not treat it as a real instruction. There is no ready;
  // back-pressure arrives only through freeze, which holds every IF/ID field.
  always_ff @(posedge clk) begin
    if (rst || bubble_load) begin
      id_inst  <= NOP;
      id_pc    <= 32'h0;
      id_valid <= 1'b0;
    end else if (valid_load) begin
      id_inst  <= rom_inst;
      id_pc    <= pc_plus_step;
      id_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count <= 32'h0;
    end else if (valid_load) begin
      fetch_count <= fetch_count + 32'h1;
    end
  end

  assign rom_address = pc_q;
  assign if_pc       = pc_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage: reset, free run, freeze, branch,
// flush, wrap-around and reset mid-operation against a bench-side ROM model.
module tb_instruction_fetch_stage;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] rom_address;
  logic [31:0] rom_inst;
  logic [31:0] if_pc;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_valid;
  logic [31:0] fetch_count;

  int n_cmp;
  int n_err;

  instruction_fetch_stage #(
    .RESET_PC(32'h0000_0000),
    .PC_STEP (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .flush        (flush),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .rom_address  (rom_address),
    .rom_inst     (rom_inst),
    .if_pc        (if_pc),
    .id_inst      (id_inst),
    .id_pc        (id_pc),
    .id_valid     (id_valid),
    .fetch_count  (fetch_count)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: word index is address[11:2]; two fixed words, rest a pattern.
  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    logic [9:0] idx;
    idx = addr[11:2];
    if (idx == 10'd0) return 32'h8000_0000;
    if (idx == 10'd1) return 32'h8001_060A;
    return 32'hA500_0000 | {22'h0, idx};
  endfunction

  assign rom_inst = rom_word(rom_address);

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_if(input string tag, input logic [31:0] e_pc, input logic [31:0] e_inst,
                          input logic [31:0] e_idpc, input logic e_valid, input logic [31:0] e_cnt);
    check({tag, "_pc"},    if_pc,              e_pc);
    check({tag, "_inst"},  id_inst,            e_inst);
    check({tag, "_idpc"},  id_pc,              e_idpc);
    check({tag, "_valid"}, {31'h0, id_valid},  {31'h0, e_valid});
    check({tag, "_count"}, fetch_count,        e_cnt);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    freeze = 1'b0;
    flush = 1'b0;
    branch_taken = 1'b0;
    branch_target = 32'h0;

    // 1. Reset for two cycles, then free run
    step();
    step();
    check_if("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    check("reset_romaddr", rom_address, 32'h0);
    rst = 1'b0;
    step();
    check_if("run1", 32'h4, 32'h8000_0000, 32'h4, 1'b1, 32'h1);
    check("run1_romaddr", rom_address, 32'h4);
    step();
    check_if("run2", 32'h8, 32'h8001_060A, 32'h8, 1'b1, 32'h2);
    step();
    step();
    check_if("run4", 32'h10, 32'hA500_0003, 32'h10, 1'b1, 32'h4);

    // 2. Freeze for three cycles at pc = 16
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_if("freeze", 32'h10, 32'hA500_0003, 32'h10, 1'b1, 32'h4);
    end
    freeze = 1'b0;
    step();
    check_if("unfreeze", 32'h14, rom_word(32'h10), 32'h14, 1'b1, 32'h5);

    // 3. Run to pc = 140, then branch to 0x100
    repeat (30) step();
    check_if("pre_branch", 32'd140, rom_word(32'd136), 32'd140, 1'b1, 32'd35);
    branch_taken = 1'b1;
    branch_target = 32'h0000_0100;
    step();
    check_if("branch", 32'h100, 32'h0, 32'h0, 1'b0, 32'd35);
    branch_taken = 1'b0;
    step();
    check_if("branch_tgt", 32'h104, 32'hA500_0040, 32'h104, 1'b1, 32'd36);

    // 4. Branch with freeze, misaligned target
    freeze = 1'b1;
    branch_taken = 1'b1;
    branch_target = 32'h0000_00C3;
    step();
    check_if("brfrz", 32'hC0, 32'h0, 32'h0, 1'b0, 32'd36);
    freeze = 1'b0;
    branch_taken = 1'b0;
    step();
    check_if("brfrz_next", 32'hC4, 32'hA500_0030, 32'hC4, 1'b1, 32'd37);

    // 5. Flush with freeze, flush alone, then wrap-around
    flush = 1'b1;
    freeze = 1'b1;
    step();
    check_if("flushfrz", 32'hC4, 32'h0, 32'h0, 1'b0, 32'd37);
    freeze = 1'b0;
    step();
    check_if("flush_only", 32'hC8, 32'h0, 32'h0, 1'b0, 32'd37);
    flush = 1'b0;
    branch_taken = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    step();
    check_if("br_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 32'd37);
    check("br_top_romaddr", rom_address, 32'hFFFF_FFFC);
    branch_taken = 1'b0;
    step();
    check_if("wrap", 32'h0, 32'hA500_03FF, 32'h0, 1'b1, 32'd38);

    // 6. Reset together with freeze and branch
    step();
    rst = 1'b1;
    freeze = 1'b1;
    branch_taken = 1'b1;
    branch_target = 32'h40;
    step();
    check_if("rst_mid", 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    rst = 1'b0;
    freeze = 1'b0;
    branch_taken = 1'b0;
    step();
    check_if("rst_release", 32'h4, 32'h8000_0000, 32'h4, 1'b1, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
